dsp_rr_scheduler: RTL and testbench

- Round-robin scheduler sharing one input/output-registered 2x2-bit DSP tile between NUM_REQ requesters.
- Accepts operand requests over valid/ready, drives the DSP operand/mode inputs, and tracks each issued operation through the DSP pipeline.
- Routes each result back to its issuing requester exactly DSP_LATENCY cycles after issue.
- Sits between requester logic and the DSP tile; the DSP itself is instantiated outside this block.

---
 rtl/dsp_rr_scheduler.sv | 120 ++++++++++++
 tb/tb_dsp_rr_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_rr_scheduler.sv
// dsp_rr_scheduler
//   Round-robin front end for one shared, input/output-registered DSP tile.
//   Requesters present operands over valid/ready. One request is granted
//   per cycle and its operands are steered onto the DSP inputs. A tag
//   pipeline that is DSP_LATENCY stages deep tracks who issued each
//   operation. The result that appears on dsp_out is then strobed back to
//   that requester.
//
// Ports
//   clk        clock shared with the DSP tile
//   rst_n      asynchronous active-low reset
//   hold       1 = issue no new grants; in-flight work still drains
//   req_valid  per-requester request valid
//   req_ready  per-requester grant (one-hot or zero)
//   req_a      packed operand A, requester i at [i*OP_WIDTH +: OP_WIDTH]
//   req_b      packed operand B, same packing
//   req_m      per-requester mode bit (passed through untouched)
//   dsp_a      operand A to the DSP
//   dsp_b      operand B to the DSP
//   dsp_m      mode bit to the DSP
//   dsp_out    result from the DSP
//   rsp_valid  one-hot result strobe, one cycle wide
//   rsp_data   result data, broadcast to all requesters
//   busy       1 while any operation is in flight
module dsp_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int OP_WIDTH    = 2,
  parameter int RES_WIDTH   = 4,
  parameter int DSP_LATENCY = 2,
  parameter int ID_WIDTH    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ-1:0]           req_m,
  output logic [OP_WIDTH-1:0]          dsp_a,
  output logic [OP_WIDTH-1:0]          dsp_b,
  output logic                         dsp_m,
  input  logic [RES_WIDTH-1:0]         dsp_out,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [RES_WIDTH-1:0]         rsp_data,
  output logic                         busy
);

  logic [ID_WIDTH-1:0]    last_grant_reg;
  logic [DSP_LATENCY-1:0] tag_valid_reg;
  logic [ID_WIDTH-1:0]    tag_id_reg [DSP_LATENCY];

  logic                   grant_any;
  logic [ID_WIDTH-1:0]    grant_id;

  // Round-robin search. The loop walks the offsets from farthest to
  // nearest. Each later hit overwrites the previous one, so the requester
  // closest after last_grant wins. The grant is also gated by rst_n, so
  // nothing is granted while reset is asserted.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_reg) + k) % NUM_REQ;
      if (req_valid[idx] && !hold && rst_n) begin
        grant_any = 1'b1;
        grant_id  = ID_WIDTH'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_ready[gi] = grant_any && (grant_id == ID_WIDTH'(gi));
      assign rsp_valid[gi] = tag_valid_reg[DSP_LATENCY-1] &&
                             (tag_id_reg[DSP_LATENCY-1] == ID_WIDTH'(gi));
    end
  endgenerate

  // Operand steering. The DSP inputs are driven to zero when nothing is granted.
  always_comb begin
    dsp_a = '0;
    dsp_b = '0;
    dsp_m = 1'b0;
    if (grant_any) begin
      dsp_a = req_a[grant_id*OP_WIDTH +: OP_WIDTH];
      dsp_b = req_b[grant_id*OP_WIDTH +: OP_WIDTH];
      dsp_m = req_m[grant_id];
    end
  end

  // The tag pipeline runs in lockstep with the DSP registers. The DSP
  // registers themselves are not reset, so clearing the tags here is what
  // drops the operations that were in flight when reset arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      tag_valid_reg  <= '0;
      for (int s = 0; s < DSP_LATENCY; s++) begin
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_valid_reg[0] <= grant_any;
      tag_id_reg[0]    <= grant_id;
      for (int s = 1; s < DSP_LATENCY; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
      if (grant_any) begin
        last_grant_reg <= grant_id;
      end
    end
  end

  assign rsp_data = dsp_out;
  assign busy     = |tag_valid_reg;

endmodule

// File: tb/tb_dsp_rr_scheduler.sv
module tb_dsp_rr_scheduler;
  localparam int N   = 4;
  localparam int OW  = 2;
  localparam int RW  = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*OW-1:0]   req_a = '0;
  logic [N*OW-1:0]   req_b = '0;
  logic [N-1:0]      req_m = '0;
  logic [OW-1:0]     dsp_a;
  logic [OW-1:0]     dsp_b;
  logic              dsp_m;
  logic [RW-1:0]     dsp_out = '0;
  logic [N-1:0]      rsp_valid;
  logic [RW-1:0]     rsp_data;
  logic              busy;

  dsp_rr_scheduler #(
    .NUM_REQ(N), .OP_WIDTH(OW), .RES_WIDTH(RW), .DSP_LATENCY(LAT), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_m(req_m),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_m(dsp_m), .dsp_out(dsp_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // DSP tile model: m=0 multiplies, m=1 adds. It has an input register and
  // an output register and is never reset.
  function automatic logic [RW-1:0] dsp_f(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic m);
    logic [RW-1:0] ea;
    logic [RW-1:0] eb;
    ea = RW'(a);
    eb = RW'(b);
    return m ? (ea + eb) : (ea * eb);
  endfunction

  logic [OW-1:0] dsp_ia = '0;
  logic [OW-1:0] dsp_ib = '0;
  logic          dsp_im = 1'b0;
  always @(posedge clk) begin
    dsp_ia  <= dsp_a;
    dsp_ib  <= dsp_b;
    dsp_im  <= dsp_m;
    dsp_out <= dsp_f(dsp_ia, dsp_ib, dsp_im);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  vec;
    logic [RW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] a_cur [N];
  logic [OW-1:0] b_cur [N];
  logic          m_cur [N];

  // One bench cycle. Inputs are driven 1 time unit after the rising edge.
  // req_ready and the DSP drive are checked on the falling edge. A granted
  // issue pushes its expected response, which is due two cycles later.
  task automatic step(input logic [N-1:0] v, input logic h, input logic r,
                      input logic [N-1:0] exp_rdy);
    int id;
    logic [OW-1:0] ea;
    logic [OW-1:0] eb;
    logic em;
    exp_t e;
    @(posedge clk);
    #1;
    if (!r) sb.delete();
    rst_n = r;
    hold = h;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*OW +: OW] = a_cur[i];
      req_b[i*OW +: OW] = b_cur[i];
      req_m[i] = m_cur[i];
    end
    @(negedge clk);
    total++;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("FAIL ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy);
    end
    id = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) id = i;
    ea = '0; eb = '0; em = 1'b0;
    if (id >= 0) begin
      ea = a_cur[id]; eb = b_cur[id]; em = m_cur[id];
    end
    total++;
    if ({dsp_a, dsp_b, dsp_m} !== {ea, eb, em}) begin
      bad++;
      $display("FAIL dsp_drive cyc=%0d got=%h/%h/%b want=%h/%h/%b",
               cyc, dsp_a, dsp_b, dsp_m, ea, eb, em);
    end
    if (id >= 0) begin
      e.vec = exp_rdy;
      e.data = dsp_f(ea, eb, em);
      e.due = cyc + LAT;
      sb.push_back(e);
      $display("issue cyc=%0d req=%0d a=%0d b=%0d m=%0d", cyc, id, ea, eb, em);
      a_cur[id] = a_cur[id] + 2'd1;
      b_cur[id] = b_cur[id] + 2'd3;
      m_cur[id] = ~m_cur[id];
    end
  endtask

  // Monitor: compares rsp_valid, rsp_data and busy every cycle against the
  // head of the scoreboard.
  initial begin
    logic [N-1:0] exp_vec;
    logic exp_busy;
    forever begin
      @(negedge clk);
      #2;
      exp_vec = '0;
      exp_busy = 1'b0;
      if (sb.size() > 0) begin
        exp_busy = (sb[0].due <= cyc + 1);
        if (sb[0].due == cyc) exp_vec = sb[0].vec;
      end
      total++;
      if (rsp_valid !== exp_vec) begin
        bad++;
        $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, exp_vec);
      end
      if (exp_vec != '0) begin
        total++;
        if (rsp_data !== sb[0].data) begin
          bad++;
          $display("FAIL rsp_data cyc=%0d got=%0d want=%0d", cyc, rsp_data, sb[0].data);
        end else begin
          $display("resp cyc=%0d vec=%b data=%0d", cyc, rsp_valid, rsp_data);
        end
        void'(sb.pop_front());
      end
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
      end
    end
  end

  initial begin
    logic [N-1:0] rr_seq [6];
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001; rr_seq[5] = 4'b0010;
    for (int i = 0; i < N; i++) begin
      a_cur[i] = OW'(i);
      b_cur[i] = OW'(3 - i);
      m_cur[i] = i[0];
    end
    a_cur[0] = 2'd3; b_cur[0] = 2'd2; m_cur[0] = 1'b0;

    // Reset with requests pending: no grants while reset is asserted.
    step(4'b1111, 1'b0, 1'b0, 4'b0000);
    step(4'b1111, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 1'b1, 4'b0000);

    // Single issue from requester 0 (3*2 = 6), then drain.
    step(4'b0001, 1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000);

    // Fresh reset, then all four requesters valid: rotation 0,1,2,3,0,1.
    step(4'b1111, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b1, rr_seq[i]);

    // last_grant = 1 with 1010 valid: 3 first, then wrap to 1.
    step(4'b1010, 1'b0, 1'b1, 4'b1000);
    step(4'b1010, 1'b0, 1'b1, 4'b0010);
    step(4'b1010, 1'b0, 1'b1, 4'b1000);
    step(4'b1010, 1'b0, 1'b1, 4'b0010);

    // Two issues, then hold with requests pending, then release at last+1.
    step(4'b1111, 1'b0, 1'b1, 4'b0100);
    step(4'b1111, 1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b1, 4'b0000);
    step(4'b1111, 1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000);

    // Reset pulse with two operations in flight: both are discarded.
    step(4'b1111, 1'b0, 1'b1, 4'b0010);
    step(4'b1111, 1'b0, 1'b1, 4'b0100);
    step(4'b1111, 1'b0, 1'b0, 4'b0000);
    step(4'b1111, 1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000);

    // Requester 2 alone for five cycles: back-to-back grants.
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b0, 1'b1, 4'b0100);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
